// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine cycle controller.
//   - state encodings (the 3-bit values appear on the 'state' output)
//   - fault cause codes reported on 'fault_Code'
//   - counter width helpers used by the controller, the interface and the phase timers
package wm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_START = 3'd0;
  localparam state_t ST_READY = 3'd1;
  localparam state_t ST_FILL  = 3'd2;
  localparam state_t ST_HEAT  = 3'd3;
  localparam state_t ST_WASH  = 3'd4;
  localparam state_t ST_RINSE = 3'd5;
  localparam state_t ST_SPIN  = 3'd6;
  localparam state_t ST_FAULT = 3'd7;

  typedef logic [2:0] fault_code_t;

  localparam fault_code_t FC_NONE         = 3'd0;
  localparam fault_code_t FC_FILL_TIMEOUT = 3'd1;
  localparam fault_code_t FC_HEAT_TIMEOUT = 3'd2;
  localparam fault_code_t FC_IMBALANCE    = 3'd3;
  localparam fault_code_t FC_MOTOR        = 3'd4;
  localparam fault_code_t FC_PHASE_TIMEOUT= 3'd5;
  localparam fault_code_t FC_LID_OPEN     = 3'd6;

  // Bits needed to hold the values 0..max_value (never less than one bit).
  function automatic int unsigned count_width(input int unsigned max_value);
    int unsigned w;
    w = $clog2(max_value + 1);
    return (w == 0) ? 1 : w;
  endfunction

  // Bits needed for a cycle counter that runs 0..limit-1.
  function automatic int unsigned timer_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/wm_cycle_controller_if.sv
// Front-end / driver bundle of the washing-machine controller.
//   master : coin/lid/sensor front end (drives sensors, observes controls)
//   slave  : the cycle controller (observes sensors, drives controls)
// Sensor inputs : sig_Coin, sig_Cancel, sig_Lid_Closed, sig_Full, sig_Temperature,
//                 sig_Completed, sig_Out_Of_Balance, sig_Motor_Failure, hot_Mode, fault_Ack
// Control outputs: state, one-hot state decodes, water_Intake, coin_Return,
//                 fault_Cleared, cycle_Done, fault_Code, coin_Count
interface wm_cycle_controller_if
  import wm_pkg::*;
#(
  parameter int unsigned COINS_REQUIRED = 2
);
  localparam int unsigned CW = count_width(COINS_REQUIRED);

  logic          sig_Coin;
  logic          sig_Cancel;
  logic          sig_Lid_Closed;
  logic          sig_Full;
  logic          sig_Temperature;
  logic          sig_Completed;
  logic          sig_Out_Of_Balance;
  logic          sig_Motor_Failure;
  logic          hot_Mode;
  logic          fault_Ack;

  logic [2:0]    state;
  logic          start;
  logic          ready;
  logic          fill_Water_Operation;
  logic          heat_Water_Operation;
  logic          wash_Operation;
  logic          rinse_Operation;
  logic          spin_Operation;
  logic          fault;
  logic          water_Intake;
  logic          coin_Return;
  logic          fault_Cleared;
  logic          cycle_Done;
  logic [2:0]    fault_Code;
  logic [CW-1:0] coin_Count;

  modport master (
    output sig_Coin, sig_Cancel, sig_Lid_Closed, sig_Full, sig_Temperature,
           sig_Completed, sig_Out_Of_Balance, sig_Motor_Failure, hot_Mode, fault_Ack,
    input  state, start, ready, fill_Water_Operation, heat_Water_Operation,
           wash_Operation, rinse_Operation, spin_Operation, fault, water_Intake,
           coin_Return, fault_Cleared, cycle_Done, fault_Code, coin_Count
  );

  modport slave (
    input  sig_Coin, sig_Cancel, sig_Lid_Closed, sig_Full, sig_Temperature,
           sig_Completed, sig_Out_Of_Balance, sig_Motor_Failure, hot_Mode, fault_Ack,
    output state, start, ready, fill_Water_Operation, heat_Water_Operation,
           wash_Operation, rinse_Operation, spin_Operation, fault, water_Intake,
           coin_Return, fault_Cleared, cycle_Done, fault_Code, coin_Count
  );

endinterface

// File: rtl/wm_phase_timer.sv
// Per-phase watchdog counter.
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : restart from zero (phase entry); wins over enable
//   enable       : count while the owning phase is active
//   expired      : count has reached LIMIT-1 while enabled
// The count holds at LIMIT-1 so 'expired' stays up until the phase is left.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned   W    = timer_width(LIMIT);
  localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;

  assign expired = enable && (count_q == LAST);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/wm_cycle_controller.sv
// Washing-machine cycle sequencer.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wm_cycle_controller_if.slave -- sensor inputs in, valve/heater/motor
//           decodes, pulses, fault code and coin credit out
// Flow: START (collect coins) -> READY (wait for lid) -> FILL -> [HEAT] -> WASH ->
// RINSE x RINSE_PASSES -> SPIN -> START. Any phase from FILL to SPIN can drop into
// FAULT; FAULT exits on cancel (refund) or acknowledge (back to READY with credit).
module wm_cycle_controller
  import wm_pkg::*;
#(
  parameter int unsigned COINS_REQUIRED = 2,
  parameter int unsigned RINSE_PASSES   = 2,
  parameter int unsigned FILL_TIMEOUT   = 1000,
  parameter int unsigned HEAT_TIMEOUT   = 2000,
  parameter int unsigned PHASE_TIMEOUT  = 4000
) (
  input logic                  clock,
  input logic                  reset,
  wm_cycle_controller_if.slave bus
);
  localparam int unsigned   CW         = count_width(COINS_REQUIRED);
  localparam int unsigned   RW         = count_width(RINSE_PASSES);
  localparam logic [CW-1:0] COIN_FULL  = CW'(COINS_REQUIRED);
  localparam logic [RW-1:0] RINSE_DONE = RW'(RINSE_PASSES);

  state_t        state_q, state_d;
  logic [CW-1:0] coin_q, coin_d;
  logic [RW-1:0] rinse_q, rinse_d;
  fault_code_t   code_q, code_d;
  logic          hot_q, hot_d;
  logic          coin_prev_q;
  logic          coin_ret_q, coin_ret_d;
  logic          fault_clr_q, fault_clr_d;
  logic          done_q, done_d;
  logic          rinse_again;
  logic          timer_clear;
  logic          fill_expired, heat_expired, phase_expired;
  logic          coin_edge;
  logic          success;
  logic          timeout;

  assign coin_edge = bus.sig_Coin && !coin_prev_q;

  // One restart strobe feeds all watchdogs: only the one enabled in the new phase matters.
  assign timer_clear = (state_d != state_q) || rinse_again;

  wm_phase_timer #(.LIMIT(FILL_TIMEOUT)) u_fill_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (state_q == ST_FILL),
    .expired (fill_expired)
  );

  wm_phase_timer #(.LIMIT(HEAT_TIMEOUT)) u_heat_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (state_q == ST_HEAT),
    .expired (heat_expired)
  );

  wm_phase_timer #(.LIMIT(PHASE_TIMEOUT)) u_phase_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  ((state_q == ST_WASH) || (state_q == ST_RINSE) || (state_q == ST_SPIN)),
    .expired (phase_expired)
  );

  // Success condition and watchdog of whichever working phase is active.
  always_comb begin
    success = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_FILL: begin
        success = bus.sig_Full;
        timeout = fill_expired;
      end
      ST_HEAT: begin
        success = bus.sig_Temperature;
        timeout = heat_expired;
      end
      ST_WASH, ST_RINSE, ST_SPIN: begin
        success = bus.sig_Completed;
        timeout = phase_expired;
      end
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    state_d     = state_q;
    coin_d      = coin_q;
    rinse_d     = rinse_q;
    code_d      = code_q;
    hot_d       = hot_q;
    coin_ret_d  = 1'b0;
    fault_clr_d = 1'b0;
    done_d      = 1'b0;
    rinse_again = 1'b0;

    case (state_q)
      ST_START: begin
        if (bus.sig_Cancel && (coin_q != '0)) begin
          coin_d     = '0;
          coin_ret_d = 1'b1;
        end else if (coin_edge && (coin_q != COIN_FULL)) begin
          coin_d = coin_q + CW'(1);
        end
        if (coin_d == COIN_FULL) state_d = ST_READY;
      end

      ST_READY: begin
        if (bus.sig_Lid_Closed) begin
          state_d = ST_FILL;
          hot_d   = bus.hot_Mode;
        end else if (bus.sig_Cancel) begin
          state_d    = ST_START;
          coin_d     = '0;
          coin_ret_d = 1'b1;
        end
      end

      ST_FILL, ST_HEAT, ST_WASH, ST_RINSE, ST_SPIN: begin
        if (!bus.sig_Lid_Closed) begin
          state_d = ST_FAULT;
          code_d  = FC_LID_OPEN;
        end else if (success) begin
          case (state_q)
            ST_FILL: state_d = hot_q ? ST_HEAT : ST_WASH;
            ST_HEAT: state_d = ST_WASH;
            ST_WASH: begin
              state_d = ST_RINSE;
              rinse_d = '0;
            end
            ST_RINSE: begin
              rinse_d = rinse_q + RW'(1);
              if (rinse_d == RINSE_DONE) state_d = ST_SPIN;
              else                       rinse_again = 1'b1;
            end
            default: begin
              state_d = ST_START;
              coin_d  = '0;
              done_d  = 1'b1;
            end
          endcase
        end else if (bus.sig_Motor_Failure &&
                     ((state_q == ST_RINSE) || (state_q == ST_SPIN))) begin
          state_d = ST_FAULT;
          code_d  = FC_MOTOR;
        end else if (bus.sig_Out_Of_Balance &&
                     ((state_q == ST_WASH) || (state_q == ST_SPIN))) begin
          state_d = ST_FAULT;
          code_d  = FC_IMBALANCE;
        end else if (timeout) begin
          state_d = ST_FAULT;
          case (state_q)
            ST_FILL: code_d = FC_FILL_TIMEOUT;
            ST_HEAT: code_d = FC_HEAT_TIMEOUT;
            default: code_d = FC_PHASE_TIMEOUT;
          endcase
        end
      end

      default: begin  // ST_FAULT
        if (bus.sig_Cancel) begin
          state_d    = ST_START;
          coin_d     = '0;
          code_d     = FC_NONE;
          coin_ret_d = 1'b1;
        end else if (bus.fault_Ack) begin
          state_d     = ST_READY;
          code_d      = FC_NONE;
          fault_clr_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_START;
      coin_q      <= '0;
      rinse_q     <= '0;
      code_q      <= FC_NONE;
      hot_q       <= 1'b0;
      coin_prev_q <= 1'b0;
      coin_ret_q  <= 1'b0;
      fault_clr_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      rinse_q     <= rinse_d;
      code_q      <= code_d;
      hot_q       <= hot_d;
      coin_prev_q <= bus.sig_Coin;
      coin_ret_q  <= coin_ret_d;
      fault_clr_q <= fault_clr_d;
      done_q      <= done_d;
    end
  end

  assign bus.state                = state_q;
  assign bus.start                = (state_q == ST_START);
  assign bus.ready                = (state_q == ST_READY);
  assign bus.fill_Water_Operation = (state_q == ST_FILL);
  assign bus.heat_Water_Operation = (state_q == ST_HEAT);
  assign bus.wash_Operation       = (state_q == ST_WASH);
  assign bus.rinse_Operation      = (state_q == ST_RINSE);
  assign bus.spin_Operation       = (state_q == ST_SPIN);
  assign bus.fault                = (state_q == ST_FAULT);
  assign bus.water_Intake         = (state_q == ST_FILL);
  assign bus.coin_Return          = coin_ret_q;
  assign bus.fault_Cleared        = fault_clr_q;
  assign bus.cycle_Done           = done_q;
  assign bus.fault_Code           = code_q;
  assign bus.coin_Count           = coin_q;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Directed bench for wm_cycle_controller with default parameters. Each step queues the
// expected outputs, advances one clock, then pops and compares against the DUT.
module tb_wm_cycle_controller;
  import wm_pkg::*;

  localparam int unsigned COINS = 2;
  localparam int unsigned CW    = count_width(COINS);

  typedef struct packed {
    logic [2:0]    st;
    logic [CW-1:0] cnt;
    logic [2:0]    code;
    logic          ret;
    logic          clr;
    logic          done;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  wm_cycle_controller_if #(.COINS_REQUIRED(COINS)) bus ();

  wm_cycle_controller #(
    .COINS_REQUIRED (COINS),
    .RINSE_PASSES   (2),
    .FILL_TIMEOUT   (1000),
    .HEAT_TIMEOUT   (2000),
    .PHASE_TIMEOUT  (4000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t       e;
    logic [7:0] onehot;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      return;
    end
    e      = sb_q.pop_front();
    onehot = 8'b1 << e.st;
    check({tag, ".state"},  32'(bus.state), 32'(e.st));
    check({tag, ".decode"},
          32'({bus.fault, bus.spin_Operation, bus.rinse_Operation, bus.wash_Operation,
               bus.heat_Water_Operation, bus.fill_Water_Operation, bus.ready, bus.start}),
          32'(onehot));
    check({tag, ".water"},  32'(bus.water_Intake), 32'(e.st == ST_FILL));
    check({tag, ".coins"},  32'(bus.coin_Count), 32'(e.cnt));
    check({tag, ".code"},   32'(bus.fault_Code), 32'(e.code));
    check({tag, ".ret"},    32'(bus.coin_Return), 32'(e.ret));
    check({tag, ".clr"},    32'(bus.fault_Cleared), 32'(e.clr));
    check({tag, ".done"},   32'(bus.cycle_Done), 32'(e.done));
  endtask

  // Queue the outputs expected after the next rising edge, clock once, compare.
  task automatic step(input string tag, input logic [2:0] st, input logic [CW-1:0] cnt,
                      input logic [2:0] code, input logic ret, input logic clr,
                      input logic done);
    sb_q.push_back('{st: st, cnt: cnt, code: code, ret: ret, clr: clr, done: done});
    @(posedge clock);
    #1;
    compare_out(tag);
  endtask

  // Two coin edges from START with the lid open; ends in READY with full credit.
  task automatic insert_coins(input string tag);
    bus.sig_Coin = 1'b1; step({tag, ".coin1"},  ST_START, 1, 0, 0, 0, 0);
    bus.sig_Coin = 1'b0; step({tag, ".coin1l"}, ST_START, 1, 0, 0, 0, 0);
    bus.sig_Coin = 1'b1; step({tag, ".coin2"},  ST_READY, 2, 0, 0, 0, 0);
    bus.sig_Coin = 1'b0; step({tag, ".coin2l"}, ST_READY, 2, 0, 0, 0, 0);
  endtask

  initial begin
    reset                  = 1'b1;
    bus.sig_Coin           = 1'b0;
    bus.sig_Cancel         = 1'b0;
    bus.sig_Lid_Closed     = 1'b0;
    bus.sig_Full           = 1'b0;
    bus.sig_Temperature    = 1'b0;
    bus.sig_Completed      = 1'b0;
    bus.sig_Out_Of_Balance = 1'b0;
    bus.sig_Motor_Failure  = 1'b0;
    bus.hot_Mode           = 1'b0;
    bus.fault_Ack          = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    sb_q.push_back('{st: ST_START, cnt: 0, code: 0, ret: 0, clr: 0, done: 0});
    compare_out("reset");
    reset = 1'b0;

    // Full hot cycle: 0,1,2,3,4,5,5,6,0 with one cycle_Done
    insert_coins("hot");
    bus.sig_Lid_Closed = 1'b1; bus.hot_Mode = 1'b1;
    step("hot.fill", ST_FILL, 2, 0, 0, 0, 0);
    bus.hot_Mode = 1'b0; bus.sig_Full = 1'b1;
    step("hot.heat", ST_HEAT, 2, 0, 0, 0, 0);
    bus.sig_Full = 1'b0; bus.sig_Temperature = 1'b1;
    step("hot.wash", ST_WASH, 2, 0, 0, 0, 0);
    bus.sig_Temperature = 1'b0; bus.sig_Completed = 1'b1;
    step("hot.rinse0", ST_RINSE, 2, 0, 0, 0, 0);
    step("hot.rinse1", ST_RINSE, 2, 0, 0, 0, 0);
    step("hot.spin",   ST_SPIN,  2, 0, 0, 0, 0);
    step("hot.done",   ST_START, 0, 0, 0, 0, 1);
    bus.sig_Completed = 1'b0; bus.sig_Lid_Closed = 1'b0;
    step("hot.idle",   ST_START, 0, 0, 0, 0, 0);

    // Cold cycle, success beats imbalance, lid opens in SPIN, cancel beats ack
    insert_coins("cold");
    bus.sig_Lid_Closed = 1'b1; bus.hot_Mode = 1'b0;
    step("cold.fill", ST_FILL, 2, 0, 0, 0, 0);
    bus.sig_Full = 1'b1;
    step("cold.wash", ST_WASH, 2, 0, 0, 0, 0);
    bus.sig_Full = 1'b0; bus.sig_Completed = 1'b1; bus.sig_Out_Of_Balance = 1'b1;
    step("cold.oob_vs_done", ST_RINSE, 2, 0, 0, 0, 0);
    bus.sig_Out_Of_Balance = 1'b0;
    step("cold.rinse1", ST_RINSE, 2, 0, 0, 0, 0);
    step("cold.spin",   ST_SPIN,  2, 0, 0, 0, 0);
    bus.sig_Completed = 1'b0; bus.sig_Lid_Closed = 1'b0;
    step("cold.lidfault", ST_FAULT, 2, FC_LID_OPEN, 0, 0, 0);
    bus.sig_Cancel = 1'b1; bus.fault_Ack = 1'b1;
    step("cold.cancel_ack", ST_START, 0, 0, 1, 0, 0);
    bus.sig_Cancel = 1'b0; bus.fault_Ack = 1'b0;
    step("cold.idle", ST_START, 0, 0, 0, 0, 0);

    // One coin then cancel in START; cancel with no credit refunds nothing
    bus.sig_Coin = 1'b1;   step("cancel.coin",  ST_START, 1, 0, 0, 0, 0);
    bus.sig_Coin = 1'b0;   step("cancel.low",   ST_START, 1, 0, 0, 0, 0);
    bus.sig_Cancel = 1'b1; step("cancel.ret",   ST_START, 0, 0, 1, 0, 0);
    step("cancel.empty", ST_START, 0, 0, 0, 0, 0);
    bus.sig_Cancel = 1'b0;

    // FILL watchdog: 1000 cycles in FILL, then FAULT code 1; ack keeps credit
    insert_coins("tmo");
    bus.sig_Lid_Closed = 1'b1;
    step("tmo.fill", ST_FILL, 2, 0, 0, 0, 0);
    for (int i = 0; i < 999; i++) step("tmo.wait", ST_FILL, 2, 0, 0, 0, 0);
    step("tmo.fault", ST_FAULT, 2, FC_FILL_TIMEOUT, 0, 0, 0);
    bus.sig_Lid_Closed = 1'b0; bus.fault_Ack = 1'b1;
    step("tmo.ack", ST_READY, 2, 0, 0, 1, 0);
    bus.fault_Ack = 1'b0;
    step("tmo.ready", ST_READY, 2, 0, 0, 0, 0);
    bus.sig_Cancel = 1'b1;
    step("tmo.cancel", ST_START, 0, 0, 1, 0, 0);
    bus.sig_Cancel = 1'b0;
    step("tmo.idle", ST_START, 0, 0, 0, 0, 0);

    // Motor failure during RINSE
    insert_coins("motor");
    bus.sig_Lid_Closed = 1'b1;
    step("motor.fill", ST_FILL, 2, 0, 0, 0, 0);
    bus.sig_Full = 1'b1;
    step("motor.wash", ST_WASH, 2, 0, 0, 0, 0);
    bus.sig_Full = 1'b0; bus.sig_Completed = 1'b1;
    step("motor.rinse", ST_RINSE, 2, 0, 0, 0, 0);
    bus.sig_Completed = 1'b0; bus.sig_Motor_Failure = 1'b1;
    step("motor.fault", ST_FAULT, 2, FC_MOTOR, 0, 0, 0);
    bus.sig_Motor_Failure = 1'b0; bus.sig_Lid_Closed = 1'b0; bus.fault_Ack = 1'b1;
    step("motor.ack", ST_READY, 2, 0, 0, 1, 0);
    bus.fault_Ack = 1'b0; bus.sig_Cancel = 1'b1;
    step("motor.cancel", ST_START, 0, 0, 1, 0, 0);
    bus.sig_Cancel = 1'b0;

    // Asynchronous reset mid-cycle while filling
    insert_coins("areset");
    bus.sig_Lid_Closed = 1'b1;
    step("areset.fill", ST_FILL, 2, 0, 0, 0, 0);
    #3 reset = 1'b1;
    #1;
    sb_q.push_back('{st: ST_START, cnt: 0, code: 0, ret: 0, clr: 0, done: 0});
    compare_out("areset.now");
    @(posedge clock);
    #1;
    bus.sig_Lid_Closed = 1'b0;
    reset = 1'b0;
    step("areset.after", ST_START, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
